ifm_buffer_pp: RTL

Parametrised ping-pong input-feature-map buffer that replaces the single-bank IFM BRAM. It holds two independent banks of DEPTH words, each DATA_W bits wide. The loader fills one bank while the compute array reads the other, and the two sides swap banks through a full/release handshake. It sits between the DMA/loader write port and the PE-array IFM read port.

---
 rtl/ifm_buf_pkg.sv | 17 +
 rtl/ifm_bank_ram.sv | 38 +++
 rtl/ifm_buffer_pp.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ifm_buf_pkg.sv
// Shared types and constants for the ping-pong IFM buffer.
package ifm_buf_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    // Bit positions inside the sticky err vector
    localparam int unsigned ERR_WR_DROP = 0;
    localparam int unsigned ERR_RD_DROP = 1;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned DEPTH_DEF    = 16384;
    localparam int unsigned RD_SHIFT_DEF = 2;

endpackage

// File: rtl/ifm_bank_ram.sv
// One IFM bank: simple dual-port block RAM with a registered read port.
module ifm_bank_ram
    import ifm_buf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when no read is issued
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ifm_buffer_pp.sv
// Ping-pong IFM buffer: loader fills one bank while the PE array reads the other.
module ifm_buffer_pp
    import ifm_buf_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned RD_SHIFT = RD_SHIFT_DEF,
    parameter int unsigned OUT_REG  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_last,
    output logic                       wr_ready,
    input  logic                       rd_en,
    input  logic [ADDR_W+RD_SHIFT-1:0] rd_addr,
    input  logic                       rd_done,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       bank_ready,
    output logic                       wr_bank,
    output logic                       rd_bank,
    output logic [1:0]                 err
);

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              wr_ready_q, wr_ready_d;
    logic              bank_ready_q, bank_ready_d;
    logic [1:0]        err_q, err_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_v1_q, rd_v1_d;

    logic              wr_acc_c, rd_acc_c, rel_acc_c;
    logic [ADDR_W-1:0] rd_word_c;
    logic [DATA_W-1:0] rdata_bank [2];
    logic [DATA_W-1:0] mux_c;

    assign wr_acc_c  = wr_en   && wr_ready_q;
    assign rd_acc_c  = rd_en   && bank_ready_q;
    assign rel_acc_c = rd_done && bank_ready_q;
    assign rd_word_c = ADDR_W'(rd_addr >> RD_SHIFT);

    // Bank states, pointers, handshake flags and sticky errors
    always_comb begin
        state_d[0]   = state_q[0];
        state_d[1]   = state_q[1];
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        err_d        = err_q;
        rd_sel_d     = rd_sel_q;
        rd_v1_d      = rd_acc_c;

        if (wr_acc_c && wr_last) begin
            state_d[wr_bank_q] = BANK_FULL;
            wr_bank_d          = ~wr_bank_q;
        end
        // Write and release always target different banks, so both may apply
        if (rel_acc_c) begin
            state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d          = ~rd_bank_q;
        end
        if (rd_acc_c) begin
            rd_sel_d = rd_bank_q;
        end
        if (wr_en && !wr_ready_q) begin
            err_d[ERR_WR_DROP] = 1'b1;
        end
        if ((rd_en || rd_done) && !bank_ready_q) begin
            err_d[ERR_RD_DROP] = 1'b1;
        end

        wr_ready_d   = (state_d[wr_bank_d] == BANK_EMPTY);
        bank_ready_d = (state_d[rd_bank_d] == BANK_FULL);
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q[0]   <= BANK_EMPTY;
            state_q[1]   <= BANK_EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_ready_q   <= 1'b1;
            bank_ready_q <= 1'b0;
            err_q        <= 2'b00;
            rd_sel_q     <= 1'b0;
            rd_v1_q      <= 1'b0;
        end else begin
            state_q[0]   <= state_d[0];
            state_q[1]   <= state_d[1];
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_ready_q   <= wr_ready_d;
            bank_ready_q <= bank_ready_d;
            err_q        <= err_d;
            rd_sel_q     <= rd_sel_d;
            rd_v1_q      <= rd_v1_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ifm_bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    (wr_acc_c && (wr_bank_q == 1'(b))),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (rd_acc_c && (rd_bank_q == 1'(b))),
            .raddr (rd_word_c),
            .rdata (rdata_bank[b])
        );
    end

    assign mux_c = rdata_bank[rd_sel_q];

    if (OUT_REG != 0) begin : g_oreg
        logic              rd_v2_q, rd_v2_d;
        logic [DATA_W-1:0] dout_q, dout_d;

        // Extra output stage; captures only valid words so rd_data holds otherwise
        always_comb begin
            rd_v2_d = rd_v1_q;
            dout_d  = dout_q;
            if (rd_v1_q) begin
                dout_d = mux_c;
            end
        end

        // Output stage registers
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_v2_q <= 1'b0;
                dout_q  <= '0;
            end else begin
                rd_v2_q <= rd_v2_d;
                dout_q  <= dout_d;
            end
        end

        assign rd_valid = rd_v2_q;
        assign rd_data  = dout_q;
    end else begin : g_noreg
        logic seen_q, seen_d;

        // RAM output is not reset, so mask it to zero until the first read lands
        always_comb begin
            seen_d = seen_q | rd_v1_q;
        end

        // First-read tracking register
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                seen_q <= 1'b0;
            end else begin
                seen_q <= seen_d;
            end
        end

        assign rd_valid = rd_v1_q;
        assign rd_data  = (seen_q || rd_v1_q) ? mux_c : '0;
    end

    assign wr_ready   = wr_ready_q;
    assign bank_ready = bank_ready_q;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign err        = err_q;

endmodule
